// File: rtl/cache_pkg.sv
// Shared widths, buffer entry layout and drain FSM states for the victim
// writeback path.
package cache_pkg;
  localparam int PTAG_W   = 44;
  localparam int VINDEX_W = 6;
  localparam int TAG_W    = PTAG_W + VINDEX_W;
  localparam int BLOCK_W  = 512;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [BLOCK_W-1:0] block;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } wb_state_t;
endpackage

// File: rtl/wb_tag_match.sv
// Parallel DEPTH-way tag compare; among matching entries the youngest one
// (closest to tail-1) wins the index select.
module wb_tag_match #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 50
) (
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags_i,
  input  logic [TAG_W-1:0]            key_i,
  input  logic [$clog2(DEPTH)-1:0]    tail_i,
  output logic                        hit_o,
  output logic [$clog2(DEPTH)-1:0]    idx_o,
  output logic [DEPTH-1:0]            match_o
);
  import cache_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] cand_s;

  // per-entry equality against the search key
  always_comb begin
    match_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_o[i] = valid_i[i] && (tags_i[i] == key_i);
    end
  end

  assign hit_o = |match_o;

  // walk oldest to youngest so the last match seen is the youngest
  always_comb begin
    idx_o  = '0;
    cand_s = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      cand_s = tail_i - IDX_W'(k);
      idx_o  = match_o[cand_s] ? cand_s : idx_o;
    end
  end
endmodule

// File: rtl/victim_writeback_buffer.sv
// Buffers dirty evicted blocks, coalesces repeat evictions, drains them to
// memory with a req/ack handshake and answers forwarding lookups.
module victim_writeback_buffer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = cache_pkg::TAG_W,
  parameter int BLOCK_W = cache_pkg::BLOCK_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       evict_valid,
  input  logic [TAG_W-1:0]           evict_tag,
  input  logic [BLOCK_W-1:0]         evict_block,
  output logic                       evict_ready,
  output logic                       mem_req_valid,
  output logic [TAG_W-1:0]           mem_req_tag,
  output logic [BLOCK_W-1:0]         mem_req_block,
  input  logic                       mem_req_ready,
  input  logic                       mem_ack,
  input  logic                       lookup_valid,
  input  logic [TAG_W-1:0]           lookup_tag,
  output logic                       lookup_hit,
  output logic [BLOCK_W-1:0]         lookup_block,
  output logic [$clog2(DEPTH):0]     count
);
  import cache_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]              valid_q;
  logic [DEPTH-1:0][TAG_W-1:0]   tag_q;
  logic [DEPTH-1:0][BLOCK_W-1:0] block_q;
  logic [IDX_W-1:0]              head_q, tail_q;
  logic [CNT_W-1:0]              count_q, count_d;
  wb_state_t                     state_q, state_d;
  logic                          lookup_hit_q;
  logic [BLOCK_W-1:0]            lookup_block_q;

  logic             enq_s, ack_s, in_flight_s, coalesce_s, append_s;
  logic [DEPTH-1:0] co_valid_s, co_match_s, lk_match_s;
  logic             co_hit_s, lk_hit_s;
  logic [IDX_W-1:0] co_idx_s, lk_idx_s;
  logic             unused_match_s;

  assign evict_ready   = (count_q != CNT_W'(DEPTH));
  assign enq_s         = evict_valid & evict_ready;
  assign ack_s         = (state_q == WAIT_ACK) & mem_ack;
  // the head also counts as in flight on the very edge memory accepts it
  assign in_flight_s   = (state_q == WAIT_ACK) | ((state_q == SEND) & mem_req_ready);
  assign coalesce_s    = enq_s & co_hit_s;
  assign append_s      = enq_s & ~co_hit_s;
  assign mem_req_tag   = tag_q[head_q];
  assign mem_req_block = block_q[head_q];
  assign lookup_hit    = lookup_hit_q;
  assign lookup_block  = lookup_block_q;
  assign count         = count_q;
  assign unused_match_s = ^{co_match_s, lk_match_s};

  // coalesce candidates exclude the in-flight head
  always_comb begin
    co_valid_s = valid_q;
    if (in_flight_s) begin
      co_valid_s[head_q] = 1'b0;
    end else begin
      co_valid_s = valid_q;
    end
  end

  wb_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_coalesce_match (
    .valid_i (co_valid_s), .tags_i (tag_q), .key_i (evict_tag), .tail_i (tail_q),
    .hit_o   (co_hit_s),   .idx_o  (co_idx_s), .match_o (co_match_s)
  );

  wb_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lookup_match (
    .valid_i (valid_q),  .tags_i (tag_q),    .key_i (lookup_tag), .tail_i (tail_q),
    .hit_o   (lk_hit_s), .idx_o  (lk_idx_s), .match_o (lk_match_s)
  );

  // occupancy: appends add, acks remove, coalesces leave it alone
  always_comb begin
    count_d = count_q;
    if (append_s && !ack_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (!append_s && ack_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // drain FSM next state and request valid
  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != CNT_W'(0)) state_d = SEND;
        else                      state_d = IDLE;
      end
      SEND: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT_ACK;
        else               state_d = SEND;
      end
      WAIT_ACK: begin
        if (mem_ack) state_d = (count_d != CNT_W'(0)) ? SEND : IDLE;
        else         state_d = WAIT_ACK;
      end
      default: state_d = IDLE;
    endcase
  end

  // control state, pointers, valid bits and registered lookup result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      lookup_hit_q   <= 1'b0;
      lookup_block_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (append_s) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + IDX_W'(1);
      end
      if (ack_s) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + IDX_W'(1);
      end
      lookup_hit_q <= lookup_valid & lk_hit_s;
      if (lookup_valid && lk_hit_s) begin
        lookup_block_q <= block_q[lk_idx_s];
      end
    end
  end

  // payload storage; stale contents are masked by the valid bits
  always_ff @(posedge clk) begin
    if (append_s) begin
      tag_q[tail_q]   <= evict_tag;
      block_q[tail_q] <= evict_block;
    end else if (coalesce_s) begin
      block_q[co_idx_s] <= evict_block;
    end
  end
endmodule

// File: tb/tb_victim_writeback_buffer.sv
// Directed bench: expected memory writes and lookup results are queued as
// stimulus is issued; monitors pop and compare when the DUT presents them.
module tb_victim_writeback_buffer;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 50;
  localparam int BLOCK_W = 512;

  localparam logic [TAG_W-1:0] T0 = 50'h1_2345_6789_ABC;
  localparam logic [TAG_W-1:0] T1 = 50'h0_00AA_0000_011;
  localparam logic [TAG_W-1:0] T2 = 50'h0_00AA_0000_022;
  localparam logic [TAG_W-1:0] T3 = 50'h0_00AA_0000_033;
  localparam logic [TAG_W-1:0] T5 = 50'h0_00AA_0000_055;

  typedef struct { logic [TAG_W-1:0] tag; logic [BLOCK_W-1:0] blk; } wr_t;
  typedef struct { logic hit; logic [BLOCK_W-1:0] blk; } lk_t;

  logic clk = 1'b0;
  logic reset, evict_valid, evict_ready, mem_req_valid, mem_req_ready;
  logic mem_ack, resp_ack, stray_ack, ack_en, lookup_valid, lookup_hit, lk_issued;
  logic [TAG_W-1:0]   evict_tag, mem_req_tag, lookup_tag;
  logic [BLOCK_W-1:0] evict_block, mem_req_block, lookup_block;
  logic [2:0]         count;
  int  n_tests = 0, n_fail = 0, ack_timer = 0;
  wr_t wr_q[$];
  lk_t lk_q[$];

  assign mem_ack = resp_ack | stray_ack;

  victim_writeback_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .BLOCK_W(BLOCK_W)) dut (
    .clk (clk), .reset (reset),
    .evict_valid (evict_valid), .evict_tag (evict_tag), .evict_block (evict_block),
    .evict_ready (evict_ready),
    .mem_req_valid (mem_req_valid), .mem_req_tag (mem_req_tag),
    .mem_req_block (mem_req_block), .mem_req_ready (mem_req_ready), .mem_ack (mem_ack),
    .lookup_valid (lookup_valid), .lookup_tag (lookup_tag),
    .lookup_hit (lookup_hit), .lookup_block (lookup_block), .count (count)
  );

  always #5 clk = ~clk;

  function automatic logic [BLOCK_W-1:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic chk(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic evict(input logic [TAG_W-1:0] tag, input logic [BLOCK_W-1:0] blk);
    evict_valid = 1'b1;
    evict_tag   = tag;
    evict_block = blk;
    tick();
    evict_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (i < budget && !(count == 3'd0 && !mem_req_valid)) begin
      tick();
      i++;
    end
    chk("drain_done", {511'd0, (count == 3'd0 && !mem_req_valid)}, 512'd1);
  endtask

  always @(posedge clk) lk_issued <= lookup_valid;

  // memory model: ack a fixed three cycles after each accepted request
  initial begin
    resp_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack = 1'b0;
      if (ack_timer > 0) begin
        ack_timer--;
        if (ack_timer == 0 && ack_en) resp_ack = 1'b1;
      end
    end
  end

  // monitor: write handshakes, lookup results, producer protocol
  initial begin
    wr_t w;
    lk_t l;
    forever begin
      @(negedge clk);
      if (!reset && mem_req_valid && mem_req_ready) begin
        ack_timer = 3;
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", {462'd0, mem_req_tag}, 512'd0);
        end else begin
          w = wr_q.pop_front();
          chk("wr_tag", {462'd0, mem_req_tag}, {462'd0, w.tag});
          chk("wr_block", mem_req_block, w.blk);
        end
      end
      if (!reset && lk_issued) begin
        if (lk_q.size() == 0) begin
          chk("lk_unexpected", {511'd0, lookup_hit}, 512'd0);
        end else begin
          l = lk_q.pop_front();
          chk("lk_hit", {511'd0, lookup_hit}, {511'd0, l.hit});
          if (l.hit) chk("lk_block", lookup_block, l.blk);
        end
      end
      if (evict_valid) chk("evict_protocol", {511'd0, evict_ready}, 512'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; evict_valid = 1'b0; evict_tag = '0; evict_block = '0;
    mem_req_ready = 1'b0; stray_ack = 1'b0; ack_en = 1'b1;
    lookup_valid = 1'b0; lookup_tag = '0;
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_count", {509'd0, count}, 512'd0);
    chk("rst_evict_ready", {511'd0, evict_ready}, 512'd1);
    chk("rst_req_valid", {511'd0, mem_req_valid}, 512'd0);
    chk("rst_lookup_hit", {511'd0, lookup_hit}, 512'd0);
    chk("rst_lookup_block", lookup_block, 512'd0);

    // single eviction and full round trip
    mem_req_ready = 1'b1;
    wr_q.push_back('{T0, fill(8'hA5)});
    evict(T0, fill(8'hA5));
    chk("t1_count", {509'd0, count}, 512'd1);
    chk("t1_req_idle", {511'd0, mem_req_valid}, 512'd0);
    tick();
    chk("t1_req_valid", {511'd0, mem_req_valid}, 512'd1);
    chk("t1_req_tag", {462'd0, mem_req_tag}, {462'd0, T0});
    wait_idle(20);
    tick();
    chk("t1_idle_stays", {511'd0, mem_req_valid}, 512'd0);

    // fill to full with memory stalled, then drain in order
    mem_req_ready = 1'b0;
    wr_q.push_back('{T0, fill(8'h01)});
    wr_q.push_back('{T1, fill(8'h02)});
    wr_q.push_back('{T2, fill(8'h03)});
    wr_q.push_back('{T3, fill(8'h04)});
    evict(T0, fill(8'h01));
    evict(T1, fill(8'h02));
    evict(T2, fill(8'h03));
    evict(T3, fill(8'h04));
    chk("t2_full_count", {509'd0, count}, 512'd4);
    chk("t2_full_ready", {511'd0, evict_ready}, 512'd0);
    mem_req_ready = 1'b1;
    tick(); tick(); tick();
    chk("t2_ready_before_ack", {511'd0, evict_ready}, 512'd0);
    tick();
    chk("t2_ready_after_ack", {511'd0, evict_ready}, 512'd1);
    chk("t2_count_after_ack", {509'd0, count}, 512'd3);
    wait_idle(100);

    // coalesce into a queued entry while the head is in flight
    wr_q.push_back('{T0, fill(8'hC0)});
    wr_q.push_back('{T1, fill(8'h22)});
    evict(T0, fill(8'hC0));
    tick(); tick();
    evict(T1, fill(8'h11));
    evict(T1, fill(8'h22));
    chk("t3_coalesce_count", {509'd0, count}, 512'd2);
    wait_idle(60);

    // same tag as the in-flight head is appended, not merged
    wr_q.push_back('{T0, fill(8'h33)});
    wr_q.push_back('{T0, fill(8'h44)});
    evict(T0, fill(8'h33));
    tick(); tick();
    evict(T0, fill(8'h44));
    chk("t4_append_count", {509'd0, count}, 512'd2);
    wait_idle(60);

    // lookups, youngest-match select, then reset mid-transaction
    ack_en = 1'b0;
    wr_q.push_back('{T2, fill(8'h5A)});
    lookup_valid = 1'b1; lookup_tag = T2;
    lk_q.push_back('{1'b0, '0});
    evict(T2, fill(8'h5A));
    lk_q.push_back('{1'b1, fill(8'h5A)});
    tick();
    lookup_tag = T3;
    lk_q.push_back('{1'b0, '0});
    tick();
    lookup_valid = 1'b0;
    evict(T2, fill(8'h6B));
    lookup_valid = 1'b1; lookup_tag = T2;
    lk_q.push_back('{1'b1, fill(8'h6B)});
    tick();
    lookup_valid = 1'b0;
    evict(T5, fill(8'h88));
    chk("t5_nolookup_hit", {511'd0, lookup_hit}, 512'd0);
    chk("t5_nolookup_block", lookup_block, fill(8'h6B));
    chk("t6_pre_count", {509'd0, count}, 512'd3);
    chk("t6_pre_waiting", {511'd0, mem_req_valid}, 512'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_count", {509'd0, count}, 512'd0);
    chk("t6_rst_req_valid", {511'd0, mem_req_valid}, 512'd0);
    chk("t6_rst_lookup_hit", {511'd0, lookup_hit}, 512'd0);
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    chk("t6_stray_ack_count", {509'd0, count}, 512'd0);
    chk("t6_stray_ack_ready", {511'd0, evict_ready}, 512'd1);
    tick(); tick(); tick();
    chk("t6_stays_idle", {511'd0, mem_req_valid}, 512'd0);

    chk("wr_queue_empty", 512'(wr_q.size()), 512'd0);
    chk("lk_queue_empty", 512'(lk_q.size()), 512'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
